if_id_register: RTL and testbench

- Pipeline register between the Instruction Fetch stage and the Instruction Decode stage of the 5-stage MIPS core.
- Captures the 64-bit IF bus {PC+4, instruction} every cycle the pipeline advances.
- Supports three controls: stall (hazard detection unit), flush (taken branch/jump resolved downstream), and freeze (debug unit step/halt control).
- Provides registered rs/rt fields for the hazard detection unit, plus an entry-valid flag.

---
 rtl/if_id_register.sv | 111 +++++++++++
 tb/tb_if_id_register.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/if_id_register.sv
// IF/ID pipeline register with stall, flush and debug freeze controls.
// Optional stall/flush performance counters are built when IF_ID_PERF_CNT_EN is defined.
module if_id_register #(
    parameter int unsigned NB_PC    = 32,
    parameter int unsigned NB_INSTR = 32,
    parameter int unsigned NB_REG   = 5,
    parameter int unsigned NB_CNT   = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NB_PC+NB_INSTR-1:0]    i_IF,
    input  logic                         i_IF_ID_write,
    input  logic                         i_flush,
    input  logic                         i_enable,
    output logic [NB_PC+NB_INSTR-1:0]    o_IF_ID,
    output logic [NB_REG-1:0]            o_rs,
    output logic [NB_REG-1:0]            o_rt,
`ifdef IF_ID_PERF_CNT_EN
    output logic [NB_CNT-1:0]            o_stall_cnt,
    output logic [NB_CNT-1:0]            o_flush_cnt,
`endif
    output logic                         o_valid
);

    localparam int unsigned NB_BUS = NB_PC + NB_INSTR;

    logic [NB_BUS-1:0] bus_q, bus_d;
    logic [NB_REG-1:0] rs_q, rs_d;
    logic [NB_REG-1:0] rt_q, rt_d;
    logic              valid_q, valid_d;

    logic do_flush;
    logic do_load;
    logic do_stall;

    // Freeze dominates everything, then flush, then the hazard unit's hold.
    assign do_flush = i_enable & i_flush;
    assign do_load  = i_enable & ~i_flush & i_IF_ID_write;
    assign do_stall = i_enable & ~i_flush & ~i_IF_ID_write;

    always_comb begin
        bus_d   = bus_q;
        rs_d    = rs_q;
        rt_d    = rt_q;
        valid_d = valid_q;
        if (do_flush) begin
            bus_d   = '0;
            rs_d    = '0;
            rt_d    = '0;
            valid_d = 1'b0;
        end else if (do_load) begin
            bus_d   = i_IF;
            rs_d    = i_IF[25:21];
            rt_d    = i_IF[20:16];
            valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus_q   <= '0;
            rs_q    <= '0;
            rt_q    <= '0;
            valid_q <= 1'b0;
        end else begin
            bus_q   <= bus_d;
            rs_q    <= rs_d;
            rt_q    <= rt_d;
            valid_q <= valid_d;
        end
    end

    assign o_IF_ID = bus_q;
    assign o_rs    = rs_q;
    assign o_rt    = rt_q;
    assign o_valid = valid_q;

`ifdef IF_ID_PERF_CNT_EN
    logic [NB_CNT-1:0] stall_cnt_q, stall_cnt_d;
    logic [NB_CNT-1:0] flush_cnt_q, flush_cnt_d;

    // Saturating counters: stop at all-ones rather than wrapping.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (do_stall && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + NB_CNT'(1);
        end
        if (do_flush && (flush_cnt_q != '1)) begin
            flush_cnt_d = flush_cnt_q + NB_CNT'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign o_stall_cnt = stall_cnt_q;
    assign o_flush_cnt = flush_cnt_q;
`else
    logic unused_stall;
    assign unused_stall = do_stall;
`endif

endmodule

// File: tb/tb_if_id_register.sv
// Self-checking bench for if_id_register: directed scenarios plus a randomized
// phase checked by a queue-based scoreboard against a behavioural model.
module tb_if_id_register;

    localparam int unsigned NB_PC    = 32;
    localparam int unsigned NB_INSTR = 32;
    localparam int unsigned NB_REG   = 5;
    localparam int unsigned NB_CNT   = 4;
    localparam int unsigned CNT_MAX  = (1 << NB_CNT) - 1;

    logic        clk = 1'b0;
    logic        rst;
    logic [63:0] i_if;
    logic        i_wr;
    logic        i_fl;
    logic        i_en;
    logic [63:0] o_if_id;
    logic [4:0]  o_rs;
    logic [4:0]  o_rt;
    logic        o_valid;
    logic [NB_CNT-1:0] o_stall_cnt;
    logic [NB_CNT-1:0] o_flush_cnt;

    if_id_register #(
        .NB_PC    (NB_PC),
        .NB_INSTR (NB_INSTR),
        .NB_REG   (NB_REG),
        .NB_CNT   (NB_CNT)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .i_IF          (i_if),
        .i_IF_ID_write (i_wr),
        .i_flush       (i_fl),
        .i_enable      (i_en),
        .o_IF_ID       (o_if_id),
        .o_rs          (o_rs),
        .o_rt          (o_rt),
`ifdef IF_ID_PERF_CNT_EN
        .o_stall_cnt   (o_stall_cnt),
        .o_flush_cnt   (o_flush_cnt),
`endif
        .o_valid       (o_valid)
    );

`ifndef IF_ID_PERF_CNT_EN
    assign o_stall_cnt = '0;
    assign o_flush_cnt = '0;
`endif

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #3;
    endtask

    // Behavioural model: what the ID stage should see after each edge.
    logic [63:0] m_if;
    logic        m_valid;
    int unsigned m_stall;
    int unsigned m_flush;

    typedef struct {
        int unsigned cyc;
        logic [63:0] ifid;
        logic        valid;
        int unsigned stall;
        int unsigned flush;
    } exp_t;

    exp_t        sb_q[$];
    int unsigned edge_cnt = 0;

    task automatic model_edge(input logic en, input logic fl, input logic wr,
                              input logic [63:0] din);
        if (!en) return;
        if (fl) begin
            m_if    = 64'd0;
            m_valid = 1'b0;
            if (m_flush < CNT_MAX) m_flush++;
        end else if (!wr) begin
            if (m_stall < CNT_MAX) m_stall++;
        end else begin
            m_if    = din;
            m_valid = 1'b1;
        end
    endtask

    // Monitor: pops the entry predicted for the edge that just occurred.
    always @(posedge clk) begin
        exp_t e;
        edge_cnt++;
        #3;
        if (sb_q.size() > 0 && sb_q[0].cyc == edge_cnt) begin
            e = sb_q.pop_front();
            chk("sb_if_id", o_if_id, e.ifid);
            chk("sb_rs", 64'(o_rs), 64'(e.ifid[25:21]));
            chk("sb_rt", 64'(o_rt), 64'(e.ifid[20:16]));
            chk("sb_valid", 64'(o_valid), 64'(e.valid));
`ifdef IF_ID_PERF_CNT_EN
            chk("sb_stall_cnt", 64'(o_stall_cnt), 64'(e.stall));
            chk("sb_flush_cnt", 64'(o_flush_cnt), 64'(e.flush));
`endif
        end
    end

    task automatic chk_all(input string tag, input logic [63:0] e_if, input logic e_v);
        chk({tag, "_if_id"}, o_if_id, e_if);
        chk({tag, "_rs"}, 64'(o_rs), 64'(e_if[25:21]));
        chk({tag, "_rt"}, 64'(o_rt), 64'(e_if[20:16]));
        chk({tag, "_valid"}, 64'(o_valid), 64'(e_v));
    endtask

    localparam logic [63:0] LW  = 64'h00000008_8C220004;
    localparam logic [63:0] ADD = 64'h0000000C_00221820;
    localparam logic [63:0] SW  = 64'h00000010_AC430008;

    initial begin
        exp_t e;
        rst  = 1'b1;
        i_if = LW;
        i_en = 1'b1;
        i_wr = 1'b1;
        i_fl = 1'b0;
        #2;
        chk_all("reset_async", 64'd0, 1'b0);
        step();
        step();
        chk_all("reset_hold", 64'd0, 1'b0);
        rst = 1'b0;

        step();
        chk_all("load_lw", LW, 1'b1);
        chk("load_rs_val", 64'(o_rs), 64'd1);
        chk("load_rt_val", 64'(o_rt), 64'd2);

        i_wr = 1'b0;
        i_if = ADD;
        for (int k = 0; k < 3; k++) begin
            step();
            chk_all("stall_hold", LW, 1'b1);
        end
        i_wr = 1'b1;
        step();
        chk_all("stall_release", ADD, 1'b1);

        i_fl = 1'b1;
        i_wr = 1'b0;
        step();
        chk_all("flush_over_stall", 64'd0, 1'b0);
`ifdef IF_ID_PERF_CNT_EN
        chk("flush_cnt_1", 64'(o_flush_cnt), 64'd1);
        chk("stall_cnt_3", 64'(o_stall_cnt), 64'd3);
`endif

        i_fl = 1'b0;
        i_wr = 1'b1;
        i_if = SW;
        step();
        chk_all("load_sw", SW, 1'b1);

        i_en = 1'b0;
        i_fl = 1'b1;
        i_if = LW;
        step();
        step();
        chk_all("freeze", SW, 1'b1);
`ifdef IF_ID_PERF_CNT_EN
        chk("freeze_flush_cnt", 64'(o_flush_cnt), 64'd1);
        chk("freeze_stall_cnt", 64'(o_stall_cnt), 64'd3);
`endif
        i_en = 1'b1;
        step();
        chk_all("unfreeze_flush", 64'd0, 1'b0);
`ifdef IF_ID_PERF_CNT_EN
        chk("unfreeze_flush_cnt", 64'(o_flush_cnt), 64'd2);
`endif

        i_fl = 1'b0;
        i_wr = 1'b0;
        for (int k = 0; k < 20; k++) step();
        chk_all("long_stall", 64'd0, 1'b0);
`ifdef IF_ID_PERF_CNT_EN
        chk("stall_cnt_sat", 64'(o_stall_cnt), 64'(CNT_MAX));
`endif
        #2;
        rst = 1'b1;
        #1;
        chk("rst_mid_cycle_stall_cnt", 64'(o_stall_cnt), 64'd0);
        chk("rst_mid_cycle_flush_cnt", 64'(o_flush_cnt), 64'd0);
        chk_all("rst_mid_cycle", 64'd0, 1'b0);
        #1;
        rst = 1'b0;

        // Randomized phase, checked by the scoreboard monitor.
        m_if    = 64'd0;
        m_valid = 1'b0;
        m_stall = 0;
        m_flush = 0;
        for (int k = 0; k < 600; k++) begin
            @(posedge clk);
            #1;
            i_en = ($urandom_range(0, 7) != 0);
            i_fl = ($urandom_range(0, 5) == 0);
            i_wr = ($urandom_range(0, 2) != 0);
            i_if = {$urandom, $urandom};
            model_edge(i_en, i_fl, i_wr, i_if);
            e.cyc   = edge_cnt + 1;
            e.ifid  = m_if;
            e.valid = m_valid;
            e.stall = m_stall;
            e.flush = m_flush;
            sb_q.push_back(e);
        end
        step();
        step();
        chk("sb_drained", 64'(sb_q.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
